bpsk_demod_param: RTL

- Parametrised integrate-and-dump BPSK correlator; successor to the fixed 8-bit single-mode demodulator.
- Multiplies each valid input sample by a reference carrier sample and accumulates over one symbol period. At the end of the period it decides the bit and presents it on a valid/ready output.
- Adds four capabilities: sample-valid gating, an erasure (low-confidence) flag, an optional differential-decoding mode and an external re-sync.
- Sits between the ADC sample stream and the bit deframer.

---
 rtl/bpsk_demod_param.sv | 101 ++++++++++
 1 files changed

// File: rtl/bpsk_demod_param.sv
// Integrate-and-dump BPSK correlator: accumulates sample*reference over one symbol,
// then presents the decided bit (optionally differentially decoded) on a valid/ready output.
module bpsk_demod_param #(
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned REF_WIDTH          = 8,
  parameter int unsigned SAMPLES_PER_SYMBOL = 16,
  parameter int unsigned ACC_WIDTH          = DATA_WIDTH + REF_WIDTH + $clog2(SAMPLES_PER_SYMBOL),
  parameter int unsigned ERASE_THRESH       = 0,
  parameter bit          DIFFERENTIAL       = 1'b0,
  localparam int unsigned PhW               = $clog2(SAMPLES_PER_SYMBOL)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic                  sample_valid,
  input  logic [REF_WIDTH-1:0]  ref_amp,
  output logic [PhW-1:0]        phase,
  input  logic                  resync,
  output logic                  bit_out,
  output logic                  erasure,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun
);

  localparam int unsigned ProdW = DATA_WIDTH + REF_WIDTH;
  localparam logic [ACC_WIDTH:0] ThreshW = (ACC_WIDTH + 1)'(ERASE_THRESH);
  localparam logic [PhW-1:0] LastPhase = PhW'(SAMPLES_PER_SYMBOL - 1);

  logic signed [ProdW-1:0]     prod;
  logic signed [ACC_WIDTH-1:0] prod_ext, total;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH:0]          total_ext, mag;
  logic [PhW-1:0]              phase_q, phase_d;
  logic                        bit_q, bit_d, era_q, era_d, prev_q, prev_d;
  logic                        valid_q, valid_d, overrun_q, overrun_d;
  logic                        decision;

  assign prod     = $signed(sample) * $signed(ref_amp);
  assign prod_ext = {{(ACC_WIDTH - ProdW){prod[ProdW-1]}}, prod};
  assign total    = acc_q + prod_ext;
  assign decision = total[ACC_WIDTH-1];

  // Magnitude taken one bit wider so the most-negative sum cannot wrap.
  assign total_ext = {total[ACC_WIDTH-1], total};
  assign mag       = total_ext[ACC_WIDTH] ? (~total_ext + (ACC_WIDTH + 1)'(1)) : total_ext;

  always_comb begin
    phase_d   = phase_q;
    acc_d     = acc_q;
    bit_d     = bit_q;
    era_d     = era_q;
    prev_d    = prev_q;
    valid_d   = valid_q & ~out_ready;
    overrun_d = overrun_q;
    if (resync) begin
      phase_d = '0;
      acc_d   = '0;
    end else if (sample_valid) begin
      if (phase_q == LastPhase) begin
        phase_d = '0;
        acc_d   = '0;
        bit_d   = DIFFERENTIAL ? (decision ^ prev_q) : decision;
        prev_d  = decision;
        era_d   = (mag < ThreshW);
        valid_d = 1'b1;
        if (valid_q && !out_ready) overrun_d = 1'b1;
      end else begin
        phase_d = phase_q + PhW'(1);
        acc_d   = total;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q   <= '0;
      acc_q     <= '0;
      bit_q     <= 1'b0;
      era_q     <= 1'b0;
      prev_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      acc_q     <= acc_d;
      bit_q     <= bit_d;
      era_q     <= era_d;
      prev_q    <= prev_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign phase     = phase_q;
  assign bit_out   = bit_q;
  assign erasure   = era_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;

endmodule
